// File: rtl/cam_init_pkg.sv
// Shared types and constants for the camera init sequencer.
package cam_init_pkg;

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      WAIT_PWUP = 4'd1,
      FETCH     = 4'd2,
      DECODE    = 4'd3,
      WRITE     = 4'd4,
      RESP      = 4'd5,
      DELAY     = 4'd6,
      DONE      = 4'd7,
      ERROR     = 4'd8
   } state_t;

   localparam logic [15:0] END_MARK   = 16'hFFFE;
   localparam logic [15:0] DELAY_MARK = 16'hFFFF;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } entry_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: one-cycle tick every CLK_FREQ/1000 cycles while enabled.
module ms_tick_gen #(
   parameter int CLK_FREQ = 74_250_000
) (
   input  logic clk_i,
   input  logic arstn_i,
   input  logic en_i,
   output logic tick_o
);
   localparam int DIV = (CLK_FREQ / 1000 > 1) ? (CLK_FREQ / 1000) : 2;
   localparam int CW  = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_r;

   // Free-running divider restarted from zero whenever the enable drops
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         cnt_r  <= '0;
         tick_o <= 1'b0;
      end else if (!en_i) begin
         cnt_r  <= '0;
         tick_o <= 1'b0;
      end else if (cnt_r == LAST) begin
         cnt_r  <= '0;
         tick_o <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + 1'b1;
         tick_o <= 1'b0;
      end
   end

endmodule

// File: rtl/cam_init_seq.sv
// Camera init sequencer: walks an external register table and issues AXI4-Lite
// writes to the SCCB master, with ms delays, response timeout and power-loss abort.
module cam_init_seq
   import cam_init_pkg::*;
#(
   parameter int  CLK_FREQ     = 74_250_000,
   parameter int  TBL_DEPTH    = 256,
   parameter int  RESP_TIMEOUT = 2_000_000,
   localparam int AW           = $clog2(TBL_DEPTH),
   localparam int TOW          = $clog2(RESP_TIMEOUT + 1)
) (
   input  logic          clk_i,
   input  logic          arstn_i,
   input  logic          start_i,
   input  logic          pwup_done_i,
   output logic [AW-1:0] tbl_addr_o,
   input  logic [23:0]   tbl_data_i,
   output logic          awvalid_o,
   input  logic          awready_i,
   output logic [15:0]   awaddr_o,
   output logic          wvalid_o,
   input  logic          wready_i,
   output logic [7:0]    wdata_o,
   output logic          wstrb_o,
   input  logic          bvalid_i,
   output logic          bready_o,
   input  logic [1:0]    bresp_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          err_o,
   output logic [AW-1:0] err_idx_o,
   output logic          csi2_enable_o
);
   state_t         state_r;
   logic [AW-1:0]  idx_r;
   logic [7:0]     ms_cnt_r;
   logic [TOW-1:0] to_cnt_r;
   logic [1:0]     rst_sync_r;
   logic           tick_s;
   entry_t         entry_s;
   logic           last_s, aw_fin_s, w_fin_s, resp_ok_s;
   logic           adv_s, fin_s, abort_s, delay_en_s;

   ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
      .clk_i   (clk_i),
      .arstn_i (arstn_i),
      .en_i    (delay_en_s),
      .tick_o  (tick_s)
   );

   // Reset release is synchronised; assertion stays asynchronous
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   // Step decisions: adv = entry finished, fin = sequence finished, abort = power lost
   always_comb begin
      entry_s    = entry_t'(tbl_data_i);
      last_s     = (idx_r == AW'(TBL_DEPTH - 1));
      aw_fin_s   = !awvalid_o || awready_i;
      w_fin_s    = !wvalid_o || wready_i;
      resp_ok_s  = (state_r == RESP) && bvalid_i && (bresp_i == 2'b00);
      delay_en_s = (state_r == DELAY);
      adv_s      = 1'b0;
      case (state_r)
         DECODE:  adv_s = (entry_s.addr == DELAY_MARK) && (entry_s.data == 8'd0);
         RESP:    adv_s = resp_ok_s;
         DELAY:   adv_s = tick_s && (ms_cnt_r == 8'd1);
         default: adv_s = 1'b0;
      endcase
      abort_s = !pwup_done_i && ((state_r == FETCH) || (state_r == DECODE) ||
                                 (state_r == DELAY) || resp_ok_s);
      fin_s   = (adv_s && last_s) || ((state_r == DECODE) && (entry_s.addr == END_MARK));
   end

   // Sequencer FSM with all outputs registered
   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_r       <= IDLE;
         idx_r         <= '0;
         ms_cnt_r      <= 8'd0;
         to_cnt_r      <= '0;
         tbl_addr_o    <= '0;
         awvalid_o     <= 1'b0;
         awaddr_o      <= 16'd0;
         wvalid_o      <= 1'b0;
         wdata_o       <= 8'd0;
         wstrb_o       <= 1'b0;
         bready_o      <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
         err_idx_o     <= '0;
         csi2_enable_o <= 1'b0;
      end else if (rst_sync_r[1]) begin
         if (abort_s) begin
            state_r    <= WAIT_PWUP;
            idx_r      <= '0;
            tbl_addr_o <= '0;
            bready_o   <= 1'b0;
         end else if (fin_s) begin
            state_r       <= DONE;
            bready_o      <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b1;
            csi2_enable_o <= 1'b1;
         end else if (adv_s) begin
            state_r    <= FETCH;
            bready_o   <= 1'b0;
            idx_r      <= idx_r + 1'b1;
            tbl_addr_o <= idx_r + 1'b1;
         end else begin
            case (state_r)
               IDLE, DONE, ERROR: begin
                  if (start_i) begin
                     state_r       <= WAIT_PWUP;
                     busy_o        <= 1'b1;
                     done_o        <= 1'b0;
                     err_o         <= 1'b0;
                     err_idx_o     <= '0;
                     csi2_enable_o <= 1'b0;
                  end
               end
               WAIT_PWUP: begin
                  if (pwup_done_i) begin
                     state_r    <= FETCH;
                     idx_r      <= '0;
                     tbl_addr_o <= '0;
                  end
               end
               FETCH: state_r <= DECODE;
               DECODE: begin
                  if (entry_s.addr == DELAY_MARK) begin
                     state_r  <= DELAY;
                     ms_cnt_r <= entry_s.data;
                  end else begin
                     state_r   <= WRITE;
                     awvalid_o <= 1'b1;
                     wvalid_o  <= 1'b1;
                     awaddr_o  <= entry_s.addr;
                     wdata_o   <= entry_s.data;
                     wstrb_o   <= 1'b1;
                  end
               end
               WRITE: begin
                  if (awready_i) awvalid_o <= 1'b0;
                  if (wready_i)  wvalid_o  <= 1'b0;
                  if (aw_fin_s && w_fin_s) begin
                     state_r  <= RESP;
                     bready_o <= 1'b1;
                     to_cnt_r <= '0;
                  end
               end
               RESP: begin
                  // An OKAY response is consumed by adv/abort above, so bvalid here is an error
                  if (bvalid_i || (to_cnt_r == TOW'(RESP_TIMEOUT - 1))) begin
                     state_r       <= ERROR;
                     bready_o      <= 1'b0;
                     busy_o        <= 1'b0;
                     err_o         <= 1'b1;
                     err_idx_o     <= idx_r;
                     csi2_enable_o <= 1'b0;
                  end else begin
                     to_cnt_r <= to_cnt_r + 1'b1;
                  end
               end
               DELAY: begin
                  if (tick_s) ms_cnt_r <= ms_cnt_r - 8'd1;
               end
               default: state_r <= IDLE;
            endcase
         end
      end
   end

endmodule
